// File: rtl/ddr_cal_pkg.sv
// Shared encodings and constants for the BEE3 RDIMM calibration sequencer.
package ddr_cal_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_BRST, S_WRCMD, S_WRWAIT, S_START, S_RDCMD,
    S_RDGAP, S_SETTLE, S_CHECK, S_DONE, S_FAIL
  } calState_e;

  localparam int CAL_READS   = 64;
  localparam int BRST_CYCLES = 4;
  localparam int FORCE_HOLD  = 2;
  localparam int DLY_STAGES  = 15;

endpackage

// File: rtl/cal_pulse_delay.sv
// Fixed-tap pulse delay line: a pulse entering on pulseIn leaves on pulseOut
// exactly `lat` cycles later; empty means no pulse is still heading for the tap.
module cal_pulse_delay
  import ddr_cal_pkg::*;
#(
  parameter int STAGES = DLY_STAGES
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic [$clog2(STAGES+1)-1:0]      lat,
  input  logic                             pulseIn,
  output logic                             pulseOut,
  output logic                             empty
);

  logic [STAGES:1] vldPipe;
  logic [STAGES:1] liveMask;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) vldPipe <= '0;
    else       vldPipe <= {vldPipe[STAGES-1:1], pulseIn};
  end

  // Stages past the tap hold pulses already delivered; ignore them for empty.
  always_comb begin
    liveMask = '0;
    for (int i = 1; i <= STAGES; i++) liveMask[i] = (i <= int'(lat));
  end

  assign pulseOut = vldPipe[lat];
  assign empty    = ~|(vldPipe & liveMask);

endmodule

// File: rtl/ddr_cal_seq.sv
// Calibration sequencer: bank reset, one forced-A write, 64 reads, settle,
// then sample per-bank CalFail; retries up to MAX_TRIES attempts.
module ddr_cal_seq
  import ddr_cal_pkg::*;
#(
  parameter int NBANKS    = 6,
  parameter int WR_LAT    = 4,
  parameter int RD_LAT    = 6,
  parameter int RD_GAP    = 8,
  parameter int SETTLE    = 256,
  parameter int MAX_TRIES = 3
) (
  input  logic              MCLK90,
  input  logic              M90ResetL,
  input  logic              CalStart,
  output logic              CmdReq,
  output logic              CmdWrite,
  input  logic              CmdAck,
  output logic              ForceA,
  output logic              StartDQCal,
  output logic              WriteBurst,
  output logic              ReadBurst,
  output logic              BankReset,
  input  logic [NBANKS-1:0] CalFail,
  output logic              CalBusy,
  output logic              CalDone,
  output logic              CalError,
  output logic [1:0]        Tries
);

  localparam int CNT_W = 16;

  calState_e        state;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       rdCnt;
  logic             ackOk, wrLaunch, rdLaunch, wrEmpty, rdEmpty;

  assign ackOk    = CmdAck & CmdReq;
  assign wrLaunch = ackOk & CmdWrite & (state == S_WRCMD);
  assign rdLaunch = ackOk & ~CmdWrite & (state == S_RDCMD);

  cal_pulse_delay uWrDly (
    .clk(MCLK90), .rstN(M90ResetL), .lat(4'(WR_LAT)),
    .pulseIn(wrLaunch), .pulseOut(WriteBurst), .empty(wrEmpty)
  );

  cal_pulse_delay uRdDly (
    .clk(MCLK90), .rstN(M90ResetL), .lat(4'(RD_LAT)),
    .pulseIn(rdLaunch), .pulseOut(ReadBurst), .empty(rdEmpty)
  );

  always_ff @(posedge MCLK90 or negedge M90ResetL) begin
    if (!M90ResetL) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rdCnt      <= '0;
      CmdReq     <= 1'b0;
      CmdWrite   <= 1'b0;
      ForceA     <= 1'b0;
      StartDQCal <= 1'b0;
      BankReset  <= 1'b0;
      CalBusy    <= 1'b0;
      CalDone    <= 1'b0;
      CalError   <= 1'b0;
      Tries      <= '0;
    end else begin
      StartDQCal <= 1'b0;
      case (state)
        S_IDLE: if (CalStart) begin
          CalDone   <= 1'b0;
          CalError  <= 1'b0;
          Tries     <= '0;
          CalBusy   <= 1'b1;
          BankReset <= 1'b1;
          cnt       <= CNT_W'(BRST_CYCLES - 1);
          state     <= S_BRST;
        end
        S_BRST: if (cnt == '0) begin
          BankReset <= 1'b0;
          CmdReq    <= 1'b1;
          CmdWrite  <= 1'b1;
          ForceA    <= 1'b1;
          state     <= S_WRCMD;
        end else cnt <= cnt - 1'b1;
        S_WRCMD: if (ackOk) begin
          CmdReq   <= 1'b0;
          CmdWrite <= 1'b0;
          state    <= S_WRWAIT;
        end
        // Hold ForceA until FORCE_HOLD cycles after the write pulse has left the line.
        S_WRWAIT: if (!wrEmpty) cnt <= CNT_W'(FORCE_HOLD - 1);
        else if (cnt == '0) begin
          ForceA     <= 1'b0;
          StartDQCal <= 1'b1;
          state      <= S_START;
        end else cnt <= cnt - 1'b1;
        S_START: begin
          rdCnt  <= '0;
          CmdReq <= 1'b1;
          state  <= S_RDCMD;
        end
        S_RDCMD: if (ackOk) begin
          CmdReq <= 1'b0;
          rdCnt  <= rdCnt + 7'd1;
          cnt    <= CNT_W'(RD_GAP - 1);
          state  <= S_RDGAP;
        end
        S_RDGAP: if (cnt == '0) begin
          if (rdCnt == 7'(CAL_READS)) begin
            cnt   <= CNT_W'(SETTLE - 1);
            state <= S_SETTLE;
          end else begin
            CmdReq <= 1'b1;
            state  <= S_RDCMD;
          end
        end else cnt <= cnt - 1'b1;
        S_SETTLE: if (!rdEmpty) cnt <= CNT_W'(SETTLE - 1);
        else if (cnt == '0) state <= S_CHECK;
        else cnt <= cnt - 1'b1;
        S_CHECK: if (~|CalFail) begin
          CalDone <= 1'b1;
          CalBusy <= 1'b0;
          state   <= S_DONE;
        end else if (Tries == 2'(MAX_TRIES - 1)) begin
          Tries    <= 2'(MAX_TRIES);
          CalError <= 1'b1;
          CalBusy  <= 1'b0;
          state    <= S_FAIL;
        end else begin
          Tries     <= Tries + 2'd1;
          BankReset <= 1'b1;
          cnt       <= CNT_W'(BRST_CYCLES - 1);
          state     <= S_BRST;
        end
        S_DONE, S_FAIL: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_cal_seq.sv
// Directed bench for ddr_cal_seq: auto-acking command responder with a
// pulse-time scoreboard, run-level count checks, retry and reset scenarios.
module tb_ddr_cal_seq;

  localparam int NB  = 6;
  localparam int WRL = 4;
  localparam int RDL = 6;
  localparam int GAP = 8;
  localparam int LIM = 20000;
  localparam logic [NB-1:0] BAD_PAT = 6'b001000;

  logic MCLK90 = 1'b0, M90ResetL = 1'b0, CalStart = 1'b0, CmdAck = 1'b0;
  logic CmdReq, CmdWrite, ForceA, StartDQCal, WriteBurst, ReadBurst, BankReset;
  logic CalBusy, CalDone, CalError;
  logic [1:0] Tries;
  logic [NB-1:0] CalFail;

  int cyc = 0, checks = 0, failures = 0;
  int ackDelay = 1, failUntil = 0, age = 0;
  int wrCount = 0, rdCount = 0, brstCount = 0, brstLen = 0;
  int lastWr = -100, sdqCyc = -1, prevRdReq = -1;
  int wrQ[$], rdQ[$];
  logic prevReq = 1'b0, prevBrst = 1'b0;

  ddr_cal_seq #(.NBANKS(NB), .WR_LAT(WRL), .RD_LAT(RDL), .RD_GAP(GAP),
                .SETTLE(256), .MAX_TRIES(3)) dut (
    .MCLK90(MCLK90), .M90ResetL(M90ResetL), .CalStart(CalStart),
    .CmdReq(CmdReq), .CmdWrite(CmdWrite), .CmdAck(CmdAck),
    .ForceA(ForceA), .StartDQCal(StartDQCal), .WriteBurst(WriteBurst),
    .ReadBurst(ReadBurst), .BankReset(BankReset), .CalFail(CalFail),
    .CalBusy(CalBusy), .CalDone(CalDone), .CalError(CalError), .Tries(Tries)
  );

  always #5 MCLK90 = ~MCLK90;
  always @(posedge MCLK90) cyc <= cyc + 1;

  // Attempt number is the count of BankReset bursts seen; fail the early ones.
  assign CalFail = (brstCount <= failUntil) ? BAD_PAT : '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge MCLK90);
    #1;
  endtask

  // Monitor + command responder, sampled on the falling edge.
  always @(negedge MCLK90) begin
    if (M90ResetL) begin
      if (WriteBurst) begin
        wrCount++;
        lastWr = cyc;
        sdqCyc = -1;
        prevRdReq = -1;
        chk("forcea_at_wb", ForceA, 1);
        chk("wb_rb_overlap", ReadBurst, 0);
        if (wrQ.size() == 0) chk("wb_unexpected", 1, 0);
        else chk("wb_latency", cyc, wrQ.pop_front());
      end
      if (ReadBurst) begin
        rdCount++;
        if (rdQ.size() == 0) chk("rb_unexpected", 1, 0);
        else chk("rb_latency", cyc, rdQ.pop_front());
      end
      if (StartDQCal) begin
        chk("sdq_after_wb", (cyc - lastWr >= 2), 1);
        sdqCyc = cyc;
      end
      if (CmdReq && !prevReq && !CmdWrite) begin
        if (prevRdReq >= 0) chk("rd_req_gap", (cyc - prevRdReq >= GAP), 1);
        else chk("sdq_before_rdreq", (sdqCyc >= 0 && cyc > sdqCyc), 1);
        prevRdReq = cyc;
      end
      if (BankReset) brstLen++;
      if (BankReset && !prevBrst) brstCount++;
      if (!BankReset && prevBrst) begin
        chk("brst_len", brstLen, 4);
        brstLen = 0;
      end
      if (CalDone && CalError) chk("done_err_excl", 1, 0);
    end
    prevReq  = CmdReq;
    prevBrst = BankReset;

    if (!M90ResetL) begin
      CmdAck = 1'b0;
      age = 0;
      brstLen = 0;
      wrQ.delete();
      rdQ.delete();
    end else if (CmdAck) begin
      CmdAck = 1'b0;
      age = 0;
    end else if (CmdReq) begin
      if (age >= ackDelay) begin
        CmdAck = 1'b1;
        if (CmdWrite) wrQ.push_back(cyc + WRL);
        else rdQ.push_back(cyc + RDL);
      end else age++;
    end else age = 0;
  end

  task automatic startCal;
    CalStart = 1'b1;
    step;
    CalStart = 1'b0;
    chk("brst_rise_1cyc", BankReset, 1);
  endtask

  task automatic doRun(input string tag, input int ad, input int failN, input int expWr,
                       input int expRd, input int expBrst, input logic expDone,
                       input int expTries, input bit poke);
    int w0, r0, b0, n;
    bit poked;
    w0 = wrCount; r0 = rdCount; b0 = brstCount; n = 0; poked = 0;
    ackDelay = ad;
    failUntil = b0 + failN;
    startCal();
    while (!(CalDone || CalError) && n < LIM) begin
      if (poke && !poked && CalBusy && !CmdReq && (rdCount - r0) >= 10) begin
        CalStart = 1'b1;
        poked = 1;
      end else CalStart = 1'b0;
      step;
      n++;
    end
    CalStart = 1'b0;
    chk({tag, "_timeout"}, (n < LIM), 1);
    chk({tag, "_wr_count"}, wrCount - w0, expWr);
    chk({tag, "_rd_count"}, rdCount - r0, expRd);
    chk({tag, "_brst_count"}, brstCount - b0, expBrst);
    chk({tag, "_done"}, CalDone, expDone);
    chk({tag, "_error"}, CalError, !expDone);
    chk({tag, "_tries"}, Tries, expTries);
    chk({tag, "_busy"}, CalBusy, 0);
    chk({tag, "_queues_drained"}, wrQ.size() + rdQ.size(), 0);
    repeat (3) step;
  endtask

  initial begin
    int r0, n;
    repeat (3) step;
    chk("reset_outputs", {CmdReq, CmdWrite, ForceA, StartDQCal, WriteBurst, ReadBurst,
                          BankReset, CalBusy, CalDone, CalError, Tries}, 0);
    M90ResetL = 1'b1;
    repeat (2) step;

    doRun("zero_lat", 1, 0, 1, 64, 1, 1'b1, 0, 0);
    doRun("stall20", 20, 0, 1, 64, 1, 1'b1, 0, 0);
    doRun("fail_all", 1, 99, 3, 192, 3, 1'b0, 3, 0);
    doRun("fail_once", 1, 1, 2, 128, 2, 1'b1, 1, 0);
    doRun("start_in_gap", 1, 0, 1, 64, 1, 1'b1, 0, 1);

    // Reset in the middle of the read phase.
    r0 = rdCount; n = 0;
    ackDelay = 1;
    failUntil = brstCount;
    startCal();
    while ((rdCount - r0) < 30 && n < LIM) begin
      step;
      n++;
    end
    chk("mid_rst_reach30", (n < LIM), 1);
    @(negedge MCLK90);
    #2 M90ResetL = 1'b0;
    #1;
    chk("mid_rst_outputs", {CmdReq, CmdWrite, ForceA, StartDQCal, WriteBurst, ReadBurst,
                            BankReset, CalBusy, CalDone, CalError, Tries}, 0);
    repeat (3) step;
    M90ResetL = 1'b1;
    repeat (40) step;
    chk("mid_rst_no_more_rb", rdCount - r0, 30);
    chk("mid_rst_idle", {CmdReq, CalBusy, BankReset, CalDone}, 0);

    doRun("post_rst", 1, 0, 1, 64, 1, 1'b1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr_cal_seq.md
# ddr_cal_seq

Calibration sequencer for the BEE3 RDIMM data path. It sits beside the main DDR command FSM and drives the broadcast calibration sideband (ForceA, StartDQCal, WriteBurst, ReadBurst) into all ddrBank instances. It requests one all-'A' write and 64 reads through a req/ack port to the command FSM, waits for every bank to finish its window search, and reports pass or fail. Failed attempts are retried after a bank reset.

## Interface
Parameters:
- NBANKS, 6: number of ddrBank instances; one CalFail bit each.
- WR_LAT, 4: cycles from CmdAck (write) to the WriteBurst pulse; range 1..15.
- RD_LAT, 6: cycles from CmdAck (read) to the ReadBurst pulse; range 1..15.
- RD_GAP, 8: minimum cycles between read CmdReq assertions; must be ≥4.
- SETTLE, 256: wait after the last ReadBurst before sampling CalFail; must be ≥200.
- MAX_TRIES, 3: number of calibration attempts before CalError.

Ports (one clock; reset is asynchronous and active-low):
- MCLK90  in  1  data-path clock.
- M90ResetL  in  1  asynchronous active-low reset.
- CalStart  in  1  one-cycle request to start calibration.
- CmdReq  out  1  command request to the DDR command FSM.
- CmdWrite  out  1  qualifies CmdReq: 1 = write, 0 = read.
- CmdAck  in  1  one-cycle acceptance of the current request.
- ForceA  out  1  to all banks; selects the 0xAAAAAA write pattern.
- StartDQCal  out  1  one-cycle pulse to all banks.
- WriteBurst  out  1  one-cycle pulse to all banks.
- ReadBurst  out  1  one-cycle pulse to all banks.
- BankReset  out  1  active-high synchronous reset to the banks.
- CalFail  in  NBANKS  per-bank failure flags.
- CalBusy  out  1  high from CalStart acceptance until CalDone or CalError.
- CalDone  out  1  sticky pass flag.
- CalError  out  1  sticky fail flag.
- Tries  out  2  attempts used so far.

## Operation
States: IDLE, BRST, WRCMD, WRWAIT, START, RDCMD, RDGAP, SETTLE, CHECK, DONE, FAIL.
- IDLE: CalStart → BRST. CalStart clears CalDone, CalError and Tries, and sets CalBusy. CalStart in any other state is ignored.
- BRST: BankReset high for exactly 4 cycles → WRCMD.
- WRCMD: hold CmdReq=1, CmdWrite=1, ForceA=1 until CmdAck → WRWAIT.
- WRWAIT:
  - Launch the write pulse into the delay line on the CmdAck cycle.
  - ForceA stays high until 2 cycles after the WriteBurst pulse, then drops.
  - Then → START.
- START: StartDQCal high for 1 cycle; load RdCnt=0 → RDCMD.
- RDCMD:
  - Hold CmdReq=1, CmdWrite=0 until CmdAck.
  - On CmdAck: launch a read pulse, RdCnt++ (7-bit counter), gap counter = RD_GAP−1 → RDGAP.
- RDGAP: count down the gap counter. At 0: if RdCnt==64 → SETTLE, else → RDCMD.
- SETTLE: wait until the read delay line is empty, then count SETTLE cycles → CHECK.
- CHECK:
  - If |CalFail == 0 → DONE.
  - Else Tries++. If Tries==MAX_TRIES → FAIL, else → BRST.
- DONE: CalDone=1, CalBusy=0 → IDLE.
- FAIL: CalError=1, CalBusy=0 → IDLE.
- Exactly one WriteBurst and exactly 64 ReadBurst pulses occur per attempt. Pulses never overlap.
- CmdAck while CmdReq=0 is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, delay lines cleared. Reset assertion mid-operation aborts immediately; no pulse is emitted after reset release.
- CalStart → BankReset rising edge: 1 cycle.
- CmdAck(write) → WriteBurst: exactly WR_LAT cycles.
- CmdAck(read) → ReadBurst: exactly RD_LAT cycles.
- StartDQCal is at least 2 cycles after WriteBurst and strictly before the first read CmdReq.
- Consecutive read CmdReq assertions are ≥RD_GAP cycles apart.
- CalFail is sampled only in CHECK, i.e. ≥SETTLE cycles after the 64th ReadBurst.
- Tries saturates at MAX_TRIES.
- CalDone and CalError are never high together.

## Structure
- Package ddr_cal_pkg holds:
  - the state encoding;
  - CAL_READS=64;
  - BRST_CYCLES=4;
  - FORCE_HOLD=2.
- Sub-module cal_pulse_delay: a 15-stage shift register with a programmable tap, one output pulse per input pulse, plus an "empty" output. It is instantiated twice, once for write and once for read.

## Test plan
- Zero-latency ack (CmdAck on the cycle after each CmdReq rises), all CalFail=0 → 1 WriteBurst exactly 4 cycles after the write CmdAck; 64 ReadBursts, each exactly 6 cycles after its read CmdAck; CalDone=1, Tries=0.
- Ack stalled 20 cycles per request → same pulse counts; all WR_LAT/RD_LAT offsets still exact; read spacing ≥8.
- CalFail[3]=1 persistently → 3 BankReset bursts of 4 cycles each; CalError=1, Tries=3, CalDone=0.
- CalFail=1 on the first attempt and 0 thereafter → CalDone=1, Tries=1, 2 WriteBursts in total.
- M90ResetL pulsed low after the 30th ReadBurst → all outputs 0 at once; no further ReadBurst; IDLE after release.
- CalStart pulsed during RDGAP → ignored; the read count still ends at exactly 64.
